// File: rtl/demux1to4_buf.sv
// 1-to-4 demultiplexer with one single-entry holding register per output channel.
// Optional DEMUX_STALL_CNT_EN adds saturating per-channel input stall counters.
module demux1to4_buf #(
    parameter int unsigned bit_size = 18,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_size-1:0]  in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [bit_size-1:0]  out0_data,
    output logic [bit_size-1:0]  out1_data,
    output logic [bit_size-1:0]  out2_data,
    output logic [bit_size-1:0]  out3_data,
`ifdef DEMUX_STALL_CNT_EN
    output logic [4*CNT_W-1:0]   stall_cnt,
`endif
    output logic [4*CNT_W-1:0]   acc_cnt
);

    localparam int unsigned NCH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    chan_state_t         r_state [NCH];
    logic [bit_size-1:0] r_data  [NCH];
    logic [CNT_W-1:0]    r_acc   [NCH];
    logic                w_accept;

    // Ready only looks at the selected channel; a full slot that drains this cycle can reload.
    assign in_ready = (r_state[in_sel] == ST_EMPTY) | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_state[k] <= ST_EMPTY;
                r_data[k]  <= '0;
                r_acc[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_accept && (in_sel == 2'(k))) begin
                    r_state[k] <= ST_FULL;
                    r_data[k]  <= in_data;
                    r_acc[k]   <= r_acc[k] + CNT_W'(1);
                end else if ((r_state[k] == ST_FULL) && out_ready[k]) begin
                    r_state[k] <= ST_EMPTY;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_out
            assign out_valid[g]                 = (r_state[g] == ST_FULL);
            assign acc_cnt[g*CNT_W +: CNT_W]    = r_acc[g];
        end
    endgenerate

    assign out0_data = r_data[0];
    assign out1_data = r_data[1];
    assign out2_data = r_data[2];
    assign out3_data = r_data[3];

`ifdef DEMUX_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall [NCH];
    logic             w_stall;

    assign w_stall = in_valid & ~in_ready;

    // Counts producer cycles blocked on each channel, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_stall[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_stall && (in_sel == 2'(k)) && (r_stall[k] != {CNT_W{1'b1}})) begin
                    r_stall[k] <= r_stall[k] + CNT_W'(1);
                end
            end
        end
    end

    generate
        for (g = 0; g < NCH; g++) begin : g_stall
            assign stall_cnt[g*CNT_W +: CNT_W] = r_stall[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Self-checking bench for demux1to4_buf: cycle model plus directed literal checks.
module tb_demux1to4_buf;

    localparam int unsigned BW    = 18;
    localparam int unsigned CW    = 8;
    localparam int          CMAX  = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [BW-1:0]   out0_data, out1_data, out2_data, out3_data;
    logic [4*CW-1:0] acc_cnt;
`ifdef DEMUX_STALL_CNT_EN
    logic [4*CW-1:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    demux1to4_buf #(.bit_size(BW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
`ifdef DEMUX_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .acc_cnt   (acc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel occupancy, last word, and counters as plain ints.
    bit            m_init = 1'b0;
    bit            m_valid [4];
    logic [BW-1:0] m_data  [4];
    int            m_acc   [4];
    int            m_stall [4];

    function automatic bit model_ready();
        return !m_valid[in_sel] || out_ready[in_sel];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_init <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                m_valid[k] <= 1'b0;
                m_data[k]  <= '0;
                m_acc[k]   <= 0;
                m_stall[k] <= 0;
            end
        end else if (m_init) begin
            for (int k = 0; k < 4; k++) begin
                if (in_valid && model_ready() && int'(in_sel) == k) begin
                    m_valid[k] <= 1'b1;
                    m_data[k]  <= in_data;
                    m_acc[k]   <= (m_acc[k] + 1) % (CMAX + 1);
                end else if (out_ready[k]) begin
                    m_valid[k] <= 1'b0;
                end
                if (in_valid && !model_ready() && int'(in_sel) == k && m_stall[k] < CMAX)
                    m_stall[k] <= m_stall[k] + 1;
            end
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        logic [3:0]      ev;
        logic [4*CW-1:0] ea;
        logic [4*CW-1:0] es;
        if (m_init) begin
            for (int k = 0; k < 4; k++) begin
                ev[k]          = m_valid[k];
                ea[k*CW +: CW] = CW'(m_acc[k]);
                es[k*CW +: CW] = CW'(m_stall[k]);
            end
            check("cyc_out_valid", 64'(out_valid), 64'(ev));
            check("cyc_in_ready",  64'(in_ready),  64'(model_ready()));
            check("cyc_out0",      64'(out0_data), 64'(m_data[0]));
            check("cyc_out1",      64'(out1_data), 64'(m_data[1]));
            check("cyc_out2",      64'(out2_data), 64'(m_data[2]));
            check("cyc_out3",      64'(out3_data), 64'(m_data[3]));
            check("cyc_acc_cnt",   64'(acc_cnt),   64'(ea));
`ifdef DEMUX_STALL_CNT_EN
            check("cyc_stall_cnt", 64'(stall_cnt), 64'(es));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        in_valid = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h3FFFF;
        in_sel    = 2'd0;
        out_ready = 4'b0000;

        // Reset held two cycles with a word offered
        cyc();
        cyc();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out0",      64'(out0_data), 64'h0);
        check("rst_acc",       64'(acc_cnt),   64'h0);
        rst = 1'b1;
        in_valid = 1'b0;
        cyc();

        // Basic steer to channel 2
        in_data = 18'h2A5A5; in_sel = 2'd2; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("steer_valid", 64'(out_valid),         64'h4);
        check("steer_data",  64'(out2_data),         64'h2A5A5);
        check("steer_acc2",  64'(acc_cnt[16 +: 8]),  64'h1);
        check("steer_out0",  64'(out0_data),         64'h0);

        // Backpressure on channel 1, then route around it to channel 3
        in_data = 18'h11111; in_sel = 2'd1; in_valid = 1'b1;
        cyc();
        in_data = 18'h22222;
        #1;
        check("bp_ready_blocked", 64'(in_ready), 64'h0);
        cyc();
        check("bp_out1_held", 64'(out1_data), 64'h11111);
        in_sel = 2'd3; in_data = 18'h33333;
        #1;
        check("bp_ready_other", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        check("bp_out3",   64'(out3_data), 64'h33333);
        check("bp_valid",  64'(out_valid), 64'hE);

        // Streaming through channel 0 at full rate
        out_ready = 4'b0001; in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = BW'(i);
            #1;
            check("stream_ready", 64'(in_ready), 64'h1);
            cyc();
            check("stream_data", 64'(out0_data), 64'(i));
        end
        in_valid = 1'b0;
        cyc();
        check("stream_drained", 64'(out_valid[0]), 64'h0);
        out_ready = 4'b0000;

        // Reset while several channels are full
        in_sel = 2'd0; in_data = 18'h00005; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("prefull_valid", 64'(out_valid), 64'hF);
        rst_pulse();
        check("rstfull_valid", 64'(out_valid), 64'h0);
        in_sel = 2'd0; in_data = 18'h0AAAA; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("postrst_valid", 64'(out_valid),       64'h1);
        check("postrst_data",  64'(out0_data),       64'h0AAAA);
        check("postrst_acc0",  64'(acc_cnt[0 +: 8]), 64'h1);

        // 256 accepts to channel 3 wrap its counter
        rst_pulse();
        out_ready = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = BW'(i);
            cyc();
        end
        in_valid = 1'b0;
        check("wrap_acc3", 64'(acc_cnt[24 +: 8]), 64'h0);
        check("wrap_out3", 64'(out3_data),        64'hFF);
        cyc();
        out_ready = 4'b0000;

`ifdef DEMUX_STALL_CNT_EN
        // 300 blocked cycles on channel 0 saturate its stall counter
        rst_pulse();
        in_sel = 2'd0; in_data = 18'h00007; in_valid = 1'b1;
        cyc();
        for (int i = 0; i < 300; i++) cyc();
        in_valid = 1'b0;
        check("stall_sat0", 64'(stall_cnt[0 +: 8]), 64'hFF);
        check("stall_acc0", 64'(acc_cnt[0 +: 8]),   64'h1);
        cyc();
`endif

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
